// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, default widths and the
// native-master bridge state encoding.
package axi4_lite_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_XFER = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/axi4_lite_native_master_bridge.sv
// Turns a CE/RD/WR native request into a single AXI4-Lite master transaction
// and reports completion with a one-cycle oREADY pulse.
module axi4_lite_native_master_bridge
  import axi4_lite_pkg::*;
#(
  parameter int         ADDR_W      = AXI_ADDR_W,
  parameter int         DATA_W      = AXI_DATA_W,
  parameter logic [2:0] PROT        = 3'b000,
  parameter bit         ALIGN_CHECK = 1'b1,
  localparam int        STRB_W      = DATA_W / 8
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iCE,
  input  logic              iRD,
  input  logic              iWR,
  input  logic [ADDR_W-1:0] iADDR,
  input  logic [DATA_W-1:0] iWDATA,
  input  logic [STRB_W-1:0] iWSTRB,
  output logic [DATA_W-1:0] oRDATA,
  output logic              oREADY,
  output logic              oERR,
  output logic              oBUSY,
  output logic              m_AWVALID,
  input  logic              m_AWREADY,
  output logic [ADDR_W-1:0] m_AWADDR,
  output logic [2:0]        m_AWPROT,
  output logic              m_WVALID,
  input  logic              m_WREADY,
  output logic [DATA_W-1:0] m_WDATA,
  output logic [STRB_W-1:0] m_WSTRB,
  input  logic              m_BVALID,
  output logic              m_BREADY,
  input  logic [1:0]        m_BRESP,
  output logic              m_ARVALID,
  input  logic              m_ARREADY,
  output logic [ADDR_W-1:0] m_ARADDR,
  output logic [2:0]        m_ARPROT,
  input  logic              m_RVALID,
  output logic              m_RREADY,
  input  logic [DATA_W-1:0] m_RDATA,
  input  logic [1:0]        m_RRESP
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STRB_W - 1);

  state_t              state_q, state_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;

  logic req;
  logic misaligned;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic aw_fin, w_fin;

  assign req        = iCE & (iRD | iWR);
  assign misaligned = ALIGN_CHECK && ((iADDR & ALIGN_MASK) != '0);

  assign aw_hs = m_AWVALID & m_AWREADY;
  assign w_hs  = m_WVALID & m_WREADY;
  assign b_hs  = m_BVALID & m_BREADY;
  assign ar_hs = m_ARVALID & m_ARREADY;
  assign r_hs  = m_RVALID & m_RREADY;

  // A channel counts as finished once its handshake has happened, either at
  // an earlier edge (flag) or at the coming one.
  assign aw_fin = aw_done_q | aw_hs;
  assign w_fin  = w_done_q | w_hs;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves a value unassigned and infers a latch.
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (misaligned) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (iWR) begin
            err_d     = 1'b0;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            awaddr_d  = iADDR;
            wdata_d   = iWDATA;
            wstrb_d   = iWSTRB;
            state_d   = WR_XFER;
          end else begin
            err_d    = 1'b0;
            araddr_d = iADDR;
            state_d  = RD_ADDR;
          end
        end
      end
      WR_XFER: begin
        aw_done_d = aw_fin;
        w_done_d  = w_fin;
        if (aw_fin && w_fin) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_RESP;
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          err_d   = (m_BRESP != RESP_OKAY);
          state_d = DONE;
        end
      end
      RD_ADDR: begin
        if (ar_hs) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (r_hs) begin
          rdata_d = m_RDATA;
          err_d   = (m_RRESP != RESP_OKAY);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  assign m_AWVALID = (state_q == WR_XFER) & ~aw_done_q;
  assign m_WVALID  = (state_q == WR_XFER) & ~w_done_q;
  assign m_BREADY  = (state_q == WR_RESP);
  assign m_ARVALID = (state_q == RD_ADDR);
  assign m_RREADY  = (state_q == RD_DATA);

  assign m_AWADDR = awaddr_q;
  assign m_ARADDR = araddr_q;
  assign m_WDATA  = wdata_q;
  assign m_WSTRB  = wstrb_q;
  assign m_AWPROT = PROT;
  assign m_ARPROT = PROT;

  assign oRDATA = rdata_q;
  assign oREADY = (state_q == DONE);
  assign oERR   = (state_q == DONE) & err_q;
  // Busy covers the in-flight states only; it is already low during DONE.
  assign oBUSY  = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: doc/axi4_lite_native_master_bridge.md
Name: axi4_lite_native_master_bridge

Overview:
- Converts a simple native memory-request interface (CE/RD/WR, address, data) into AXI4-Lite master transactions.
- It is the opposite direction of axi4_lite_slave, which turns AXI4-Lite into CE/RD/WR.
- Lets a CPU-style requester drive any AXI4-Lite slave, including axi4_lite_slave + memory, without a start-pulse controller.
- Handles one outstanding transaction at a time. Reports completion with a single-cycle oREADY pulse.

Parameters:
- ADDR_W, 32, address width on native and AXI sides.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- PROT, 3'b000, constant value driven on m_AWPROT and m_ARPROT.
- ALIGN_CHECK, 1, when 1, reject requests whose address is not DATA_W/8-aligned.

Ports:
- iCLK  in  1  clock; all logic on the rising edge.
- iRST  in  1  synchronous reset, active-low.
- iCE  in  1  native chip enable; a request is present when iCE & (iRD | iWR).
- iRD  in  1  native read request.
- iWR  in  1  native write request.
- iADDR  in  ADDR_W  native byte address.
- iWDATA  in  DATA_W  native write data.
- iWSTRB  in  DATA_W/8  native byte enables.
- oRDATA  out  DATA_W  read data; valid while oREADY=1.
- oREADY  out  1  one-cycle completion pulse.
- oERR  out  1  error flag qualified by oREADY (SLVERR, DECERR or misaligned).
- oBUSY  out  1  high from request acceptance until the cycle of oREADY.
- m_AWVALID/m_AWREADY/m_AWADDR/m_AWPROT  out/in/out/out  1/1/ADDR_W/3  write address channel.
- m_WVALID/m_WREADY/m_WDATA/m_WSTRB  out/in/out/out  1/1/DATA_W/DATA_W/8  write data channel.
- m_BVALID/m_BREADY/m_BRESP  in/out/in  1/1/2  write response channel.
- m_ARVALID/m_ARREADY/m_ARADDR/m_ARPROT  out/in/out/out  1/1/ADDR_W/3  read address channel.
- m_RVALID/m_RREADY/m_RDATA/m_RRESP  in/out/in/in  1/1/DATA_W/2  read data channel.

Behaviour:
- Reset (iRST=0 at an edge):
  - state=IDLE.
  - All VALID/READY outputs 0; oREADY=0, oERR=0, oBUSY=0.
  - oRDATA, m_AWADDR, m_ARADDR, m_WDATA, m_WSTRB = 0.
  - Reset mid-transaction abandons it immediately. No oREADY is produced. The slave is reset by the same iRST.
- Request acceptance:
  - Requests are sampled only in IDLE; they are ignored in any other state.
  - Address, data and strobe are latched at acceptance. The native side may change its inputs afterwards.
  - iRD and iWR both high: treated as a write.
- States and transitions:
  - IDLE -> WR_XFER on a write request; sets m_AWVALID=1 and m_WVALID=1 on the next cycle.
  - IDLE -> RD_ADDR on a read request; sets m_ARVALID=1.
  - IDLE -> DONE on a misaligned request when ALIGN_CHECK=1 and addr[1:0]!=0. No AXI activity; oERR=1.
  - WR_XFER: AW and W complete independently.
    - Drop each VALID the cycle after its own handshake (VALID & READY at an edge).
    - Per-channel done flags track completion.
    - Go to WR_RESP once both are done, including when both complete at the same edge.
  - WR_RESP: m_BREADY=1.
    - On the B handshake, capture err = (BRESP != 2'b00) and go to DONE.
  - RD_ADDR: hold m_ARVALID until the AR handshake, then go to RD_DATA.
  - RD_DATA: m_RREADY=1.
    - On the R handshake, capture RDATA into oRDATA and err = (RRESP != 0), then go to DONE.
  - DONE: oREADY=1 and oERR=err for exactly one cycle, then return to IDLE.
    - oBUSY falls in this same cycle. A new request is accepted only at the next edge, in IDLE.
- VALID signals are never deasserted before their handshake; AXI address and data are stable while VALID is high.
- No timeout: the bridge waits indefinitely for READY and for the response.
- Latency against a zero-wait slave: write = 4 edges from acceptance to oREADY; read = 4 edges.
- oRDATA holds its last captured value until the next read completes.
- oRDATA is not modified by writes or by error completions.

Decomposition:
- Shared package axi4_lite_pkg holds:
  - RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - The state encoding constants (IDLE, WR_XFER, WR_RESP, RD_ADDR, RD_DATA, DONE).
  - Default widths.
- No sub-module: a single FSM plus the per-channel done flags is sufficient.

Test Plan:
- Write to addr 32, data 8080, strb 4'b1111, via axi4_lite_slave + memory -> single oREADY pulse with oERR=0; memory word at 32 reads back 8080.
- Read from addr 32 after the write above -> oRDATA=8080, oREADY one cycle, oERR=0, oBUSY low afterwards.
- Slave stub holds AWREADY low 3 cycles, WREADY high immediately -> WVALID drops after 1 cycle, AWVALID held with stable AWADDR until its handshake, then BREADY rises.
- Stub returns BRESP=2'b10 for write to 32'h1000_0020 -> oREADY with oERR=1; a subsequent read with RRESP=0 gives oERR=0.
- Misaligned write to addr 15 with ALIGN_CHECK=1 -> no AWVALID/WVALID; oREADY with oERR=1 two edges after the request.
- iRST driven low during RD_DATA with RVALID withheld -> all outputs 0 next edge, no oREADY; a following read of addr 16 completes normally.
